// File: rtl/exec_muldiv_ctrl.sv
// RV32M multiply/divide sequencer for the EX stage: iterative shift-add multiply and restoring divide.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle multiply; divide stays iterative).
module exec_muldiv_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        StartE,
  input  logic        FlushE,
  input  logic [2:0]  funct3E,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  output logic        BusyE,
  output logic        DoneE,
  output logic [31:0] MDResultE
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        signA_q, signA_d, signB_q, signB_d;
  logic        special_q, special_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;

  logic        aSigned, bSigned, signAIn, signBIn, overflowIn;
  logic [31:0] magA, magB;
  logic [32:0] mulSum, divShift;
  logic        divFits;
  logic [31:0] divSub;
  logic [63:0] prodFix;
  logic [31:0] quoFix, remFix, fixRes;

  always_comb begin
    aSigned = 1'b0;
    bSigned = 1'b0;
    case (funct3E)
      3'b001, 3'b100, 3'b110: begin
        aSigned = 1'b1;
        bSigned = 1'b1;
      end
      3'b010:  aSigned = 1'b1;
      default: ;
    endcase
    signAIn    = aSigned & SrcAE[31];
    signBIn    = bSigned & SrcBE[31];
    magA       = signAIn ? (~SrcAE + 32'd1) : SrcAE;
    magB       = signBIn ? (~SrcBE + 32'd1) : SrcBE;
    overflowIn = funct3E[2] & ~funct3E[0] & (SrcAE == 32'h8000_0000) & (SrcBE == 32'hFFFF_FFFF);
  end

  // acc holds {high product, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    mulSum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    divShift = {acc_q[63:32], acc_q[31]};
    divFits  = (divShift >= {1'b0, opnd_q});
    divSub   = divShift[31:0] - opnd_q;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [63:0] fastA, fastB, fastProd;
  always_comb begin
    fastA    = {{32{signAIn}}, SrcAE};
    fastB    = {{32{signBIn}}, SrcBE};
    fastProd = fastA * fastB;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    signA_d   = signA_q;
    signB_d   = signB_q;
    special_d = special_q;
    funct3_d  = funct3_q;
    case (state_q)
      IDLE: begin
        if (StartE && !FlushE) begin
          funct3_d  = funct3E;
          signA_d   = signAIn;
          signB_d   = signBIn;
          cnt_d     = 6'd0;
          special_d = 1'b0;
          if (!funct3E[2]) begin
`ifdef MULDIV_FAST_MUL_EN
            acc_d     = fastProd;
            special_d = 1'b1;
            state_d   = DONE;
`else
            acc_d   = {32'd0, magB};
            opnd_d  = magA;
            state_d = MUL;
`endif
          end else if (SrcBE == 32'd0) begin
            acc_d     = {SrcAE, 32'hFFFF_FFFF};
            special_d = 1'b1;
            state_d   = DONE;
          end else if (overflowIn) begin
            acc_d     = {32'd0, 32'h8000_0000};
            special_d = 1'b1;
            state_d   = DONE;
          end else begin
            acc_d   = {32'd0, magA};
            opnd_d  = magB;
            state_d = DIV;
          end
        end
      end
      MUL: begin
        acc_d = {mulSum, acc_q[31:1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = DONE;
      end
      DIV: begin
        acc_d = divFits ? {divSub, acc_q[30:0], 1'b1} : {divShift[31:0], acc_q[30:0], 1'b0};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (FlushE) state_d = IDLE;
  end

  // Fixup works on next-state values so the result is registered on the edge entering DONE.
  always_comb begin
    prodFix = acc_d;
    quoFix  = acc_d[31:0];
    remFix  = acc_d[63:32];
    if (!special_d && (signA_d ^ signB_d)) begin
      prodFix = ~acc_d + 64'd1;
      quoFix  = ~acc_d[31:0] + 32'd1;
    end
    if (!special_d && signA_d) remFix = ~acc_d[63:32] + 32'd1;
    case (funct3_d)
      3'b000:                 fixRes = prodFix[31:0];
      3'b001, 3'b010, 3'b011: fixRes = prodFix[63:32];
      3'b100, 3'b101:         fixRes = quoFix;
      default:                fixRes = remFix;
    endcase
    done_d   = (state_d == DONE);
    result_d = done_d ? fixRes : result_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      signA_q   <= 1'b0;
      signB_q   <= 1'b0;
      special_q <= 1'b0;
      funct3_q  <= 3'd0;
      done_q    <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      signA_q   <= signA_d;
      signB_q   <= signB_d;
      special_q <= special_d;
      funct3_q  <= funct3_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign BusyE     = StartE & (state_q != DONE);
  assign DoneE     = done_q;
  assign MDResultE = result_q;

endmodule

// File: tb/tb_exec_muldiv_ctrl.sv
// Scoreboard bench for exec_muldiv_ctrl: stimulus pushes expected results, a monitor pops on DoneE.
// Build with MULDIV_FAST_MUL_EN defined to match a fast-multiply DUT.
module tb_exec_muldiv_ctrl;

  logic        CLK = 1'b0;
  logic        RST, StartE, FlushE;
  logic [2:0]  funct3E;
  logic [31:0] SrcAE, SrcBE;
  logic        BusyE, DoneE;
  logic [31:0] MDResultE;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 2;
`else
  localparam int MulLat = 34;
`endif

  typedef struct {
    logic [31:0] res;
    int          doneCyc;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  exp_t        monEntry;
  int          testsRun = 0;
  int          testsFailed = 0;
  int          cyc = 0;
  logic [31:0] lastResult;
  logic [2:0]  rstF3;

  exec_muldiv_ctrl dut (
    .CLK(CLK), .RST(RST), .StartE(StartE), .FlushE(FlushE), .funct3E(funct3E),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .BusyE(BusyE), .DoneE(DoneE), .MDResultE(MDResultE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model straight from the RV32M rules, using 64-bit host arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'd0;
    case (f3)
      3'b000: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'b001: begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
      3'b010: begin p = longint'($signed(a)) * longint'({32'd0, b}); return p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = longint'($signed(a)) / longint'($signed(b));
        return p[31:0];
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = longint'($signed(a)) % longint'($signed(b));
        return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latencyOf(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MulLat;
    if (b == 0) return 2;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic startOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    StartE  = 1'b1;
    funct3E = f3;
    SrcAE   = a;
    SrcBE   = b;
  endtask

  // Holds the op in EX for its whole latency, scrambling operands once it has been latched.
  task automatic applyStimulus(input string name, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expRes);
    int lat = latencyOf(f3, a, b);
    startOp(f3, a, b);
    sbq.push_back('{res: expRes, doneCyc: cyc + lat - 1, name: name});
    for (int n = 1; n <= lat; n++) begin
      @(negedge CLK);
      if (n == 1) checkOutput({name, " held result"}, MDResultE, lastResult);
      checkOutput({name, " busy"}, {31'd0, BusyE}, (n < lat) ? 32'd1 : 32'd0);
      if (n == 2 && n < lat) begin
        SrcAE   = $urandom;
        SrcBE   = $urandom;
        funct3E = 3'($urandom);
      end
    end
    lastResult = expRes;
    @(posedge CLK); #1;
  endtask

  always @(negedge CLK) begin
    if (!RST && DoneE === 1'b1) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected DoneE", 32'd1, 32'd0);
      end else begin
        monEntry = sbq.pop_front();
        checkOutput({monEntry.name, " result"}, MDResultE, monEntry.res);
        checkOutput({monEntry.name, " done cycle"}, cyc, monEntry.doneCyc);
      end
    end
  end

  initial begin
    RST = 1'b1; StartE = 1'b0; FlushE = 1'b0;
    funct3E = 3'd0; SrcAE = 32'd0; SrcBE = 32'd0;
    lastResult = 32'd0;
    rstF3 = (MulLat == 34) ? 3'b000 : 3'b101;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    @(negedge CLK);
    checkOutput("reset DoneE", {31'd0, DoneE}, 32'd0);
    checkOutput("reset MDResultE", MDResultE, 32'd0);
    checkOutput("reset BusyE", {31'd0, BusyE}, 32'd0);
    @(posedge CLK); #1;
    startOp(3'b100, 32'd100, 32'd7);
    FlushE = 1'b1;
    @(negedge CLK);
    checkOutput("idle BusyE follows StartE", {31'd0, BusyE}, 32'd1);
    @(posedge CLK); #1;
    StartE = 1'b0; FlushE = 1'b0;
    @(posedge CLK); #1;

    applyStimulus("MUL 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    applyStimulus("MULH min*min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    applyStimulus("MULHSU -1*max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus("MULHU max*max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    applyStimulus("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    applyStimulus("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    applyStimulus("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14);
    applyStimulus("REMU 100/7", 3'b111, 32'd100, 32'd7, 32'd2);
    applyStimulus("DIVU 5/0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF);
    applyStimulus("REM 5/0", 3'b110, 32'd5, 32'd0, 32'd5);
    applyStimulus("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    applyStimulus("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    startOp(3'b100, 32'hFFFF_FF9C, 32'd7);
    for (int n = 1; n <= 9; n++) @(negedge CLK);
    @(posedge CLK); #1;
    FlushE = 1'b1;
    @(posedge CLK); #1;
    FlushE = 1'b0;
    applyStimulus("MUL after flush", 3'b000, 32'd6, 32'd9, 32'd54);

    startOp(rstF3, 32'd12345, 32'd678);
    for (int n = 1; n <= 19; n++) @(negedge CLK);
    @(posedge CLK); #1;
    RST = 1'b1; FlushE = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; FlushE = 1'b0; StartE = 1'b0;
    lastResult = 32'd0;
    @(negedge CLK);
    checkOutput("mid-op reset DoneE", {31'd0, DoneE}, 32'd0);
    checkOutput("mid-op reset MDResultE", MDResultE, 32'd0);
    checkOutput("mid-op reset BusyE", {31'd0, BusyE}, 32'd0);
    @(posedge CLK); #1;

    applyStimulus("b2b DIVU", 3'b101, 32'd1000, 32'd33, 32'd30);
    applyStimulus("b2b MULHU", 3'b011, 32'h8000_0000, 32'd6, 32'd3);

    for (int i = 0; i < 20; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom);
      a  = pickOperand();
      b  = pickOperand();
      applyStimulus($sformatf("rand%0d f3=%0d", i, f3), f3, a, b, refModel(f3, a, b));
      if ($urandom_range(0, 1) == 1) begin
        StartE = 1'b0;
        @(posedge CLK); #1;
      end
    end

    StartE = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    checkOutput("scoreboard drained", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
